// File: rtl/wb_axis_rx_fifo.sv
// wb_axis_rx_fifo: AXI-Stream sample FIFO drained over Wishbone via pop-on-read data and status registers.
// Define RX_FIFO_IRQ_EN to enable the fill/last_seen level interrupt; otherwise irq is tied low.
module wb_axis_rx_fifo #(
  parameter int          DATA_W     = 32,
  parameter int          DEPTH      = 8,
  parameter logic [31:0] DATA_ADDR  = 32'h3000_0090,
  parameter logic [31:0] STAT_ADDR  = 32'h3000_0094,
  parameter int          IRQ_THRESH = 4
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_dat_i,
  input  logic [31:0]                wbs_adr_i,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_dat_o,
  input  logic                       s_tvalid,
  input  logic [DATA_W-1:0]          s_tdata,
  input  logic                       s_tlast,
  output logic                       s_tready,
  output logic [$clog2(DEPTH):0]     fill_count,
  output logic                       irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ack_q, last_q, last_d, und_q, und_d;
  logic [31:0] dat_q, dat_d, stat;
  logic [DATA_W:0] head;
  logic full, empty, push, is_data, hit, acc, rd, pop, stat_wr;
  logic unused_ok;
  assign unused_ok = ^{wbs_sel_i, wbs_dat_i[31:4], wbs_dat_i[1:0]};
  always_comb begin
    head    = mem_q[rptr_q];
    full    = cnt_q == CW'(DEPTH);
    empty   = cnt_q == '0;
    push    = s_tvalid & ~full;
    is_data = wbs_adr_i == DATA_ADDR;
    hit     = wbs_stb_i & wbs_cyc_i & (is_data | wbs_adr_i == STAT_ADDR);
    acc     = hit & ~ack_q;
    rd      = acc & ~wbs_we_i;
    pop     = rd & is_data & ~empty;
    stat_wr = acc & wbs_we_i & ~is_data;
    stat    = {16'b0, 8'(cnt_q), 3'b0, ~empty & head[DATA_W], und_q, last_q, full, empty};
    dat_d   = ~rd ? '0 : is_data ? (empty ? '0 : 32'(head[DATA_W-1:0])) : stat;
    // Set events take priority over a same-cycle W1C.
    last_d  = (push & s_tlast) | (last_q & ~(stat_wr & wbs_dat_i[2]));
    und_d   = (rd & is_data & empty) | (und_q & ~(stat_wr & wbs_dat_i[3]));
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge wb_clk_i)
    if (push) mem_q[wptr_q] <= {s_tlast, s_tdata};
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      last_q <= 1'b0;
      und_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_q + AW'(push);
      rptr_q <= rptr_q + AW'(pop);
      cnt_q  <= cnt_d;
      ack_q  <= acc;
      dat_q  <= dat_d;
      last_q <= last_d;
      und_q  <= und_d;
    end
  end
`ifdef RX_FIFO_IRQ_EN
  logic irq_q;
  always_ff @(posedge wb_clk_i)
    irq_q <= ~wb_rst_i & ((cnt_d >= CW'(IRQ_THRESH)) | last_d);
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif
  assign s_tready   = ~full;
  assign fill_count = cnt_q;
  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
endmodule

// File: tb/tb_wb_axis_rx_fifo.sv
// tb_wb_axis_rx_fifo: vector table plus scoreboarded sequences for the Wishbone-drained RX FIFO.
module tb_wb_axis_rx_fifo;
  localparam logic [31:0] DATA = 32'h3000_0090;
  localparam logic [31:0] STAT = 32'h3000_0094;
  localparam int DEPTH = 8;
  typedef enum logic [2:0] {OP_PUSH, OP_RDD, OP_WRD, OP_RDS, OP_WRS, OP_CNT} op_e;
  typedef struct {op_e op; logic [31:0] d; logic l; logic [31:0] exp;} vec_t;
  logic wb_clk_i = 0, wb_rst_i = 1;
  logic wbs_stb_i = 0, wbs_cyc_i = 0, wbs_we_i = 0;
  logic [3:0] wbs_sel_i = 4'hF;
  logic [31:0] wbs_dat_i = 0, wbs_adr_i = 0;
  logic wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic s_tvalid = 0, s_tlast = 0, s_tready, irq;
  logic [31:0] s_tdata = 0;
  logic [3:0] fill_count;
  int n_vec = 0, n_err = 0, maxc = 0;
  logic [32:0] sb[$];
  vec_t tbl[20];
  wb_axis_rx_fifo dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .fill_count(fill_count), .irq(irq)
  );
  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) if (32'(fill_count) > maxc) maxc <= 32'(fill_count);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                         output logic [31:0] rd);
    int n = 0;
    @(negedge wb_clk_i);
    if (wbs_ack_o) @(negedge wb_clk_i);
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = wd;
    @(posedge wb_clk_i); #1;
    while (!wbs_ack_o && n < 8) begin
      n++;
      @(posedge wb_clk_i); #1;
    end
    chk("ack_latency_extra", 32'(n), 32'd0);
    rd = wbs_dat_o;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
  endtask
  task automatic push(input logic [31:0] d, input logic l);
    int n = 0;
    @(negedge wb_clk_i);
    s_tvalid = 1; s_tdata = d; s_tlast = l;
    while (!s_tready && n < 64) begin
      n++;
      @(negedge wb_clk_i);
    end
    chk("push_ready", 32'(s_tready), 32'd1);
    @(posedge wb_clk_i); #1;
    s_tvalid = 0;
    sb.push_back({l, d});
  endtask
  initial begin
    logic [31:0] r;
    logic [32:0] e;
    int acks, bad, got;
    tbl[0]  = '{OP_RDS, 0, 0, 32'h1};
    tbl[1]  = '{OP_CNT, 0, 0, 0};
    tbl[2]  = '{OP_PUSH, 32'd10, 0, 0};
    tbl[3]  = '{OP_PUSH, 32'hFFFF_FFEC, 0, 0};
    tbl[4]  = '{OP_PUSH, 32'd30, 1, 0};
    tbl[5]  = '{OP_WRD, 32'hDEAD_BEEF, 0, 0};
    tbl[6]  = '{OP_CNT, 3, 0, 0};
    tbl[7]  = '{OP_RDS, 0, 0, 32'h304};
    tbl[8]  = '{OP_RDD, 0, 0, 0};
    tbl[9]  = '{OP_RDD, 0, 0, 0};
    tbl[10] = '{OP_RDS, 0, 0, 32'h114};
    tbl[11] = '{OP_RDD, 0, 0, 0};
    tbl[12] = '{OP_RDS, 0, 0, 32'h5};
    tbl[13] = '{OP_RDD, 0, 0, 0};
    tbl[14] = '{OP_RDS, 0, 0, 32'hD};
    tbl[15] = '{OP_WRS, 32'h8, 0, 0};
    tbl[16] = '{OP_RDS, 0, 0, 32'h5};
    tbl[17] = '{OP_WRS, 32'h4, 0, 0};
    tbl[18] = '{OP_RDS, 0, 0, 32'h1};
    tbl[19] = '{OP_CNT, 0, 0, 0};
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 0;
    chk("rst_ack", 32'(wbs_ack_o), 0);
    chk("rst_dat", wbs_dat_o, 0);
    chk("rst_tready", 32'(s_tready), 1);
    chk("rst_fill", 32'(fill_count), 0);
    chk("rst_irq", 32'(irq), 0);
    for (int i = 0; i < 20; i++)
      case (tbl[i].op)
        OP_PUSH: push(tbl[i].d, tbl[i].l);
        OP_RDD: begin
          e = (sb.size() > 0) ? sb.pop_front() : '0;
          wb_xfer(0, DATA, 0, r);
          chk($sformatf("vec%0d_rd_data", i), r, e[31:0]);
        end
        OP_WRD: wb_xfer(1, DATA, tbl[i].d, r);
        OP_RDS: begin
          wb_xfer(0, STAT, 0, r);
          chk($sformatf("vec%0d_rd_stat", i), r, tbl[i].exp);
        end
        OP_WRS: wb_xfer(1, STAT, tbl[i].d, r);
        default: chk($sformatf("vec%0d_fill", i), 32'(fill_count), tbl[i].d);
      endcase
    // Fill to full, then pop while a sample is held valid against the full FIFO.
    for (int i = 1; i <= DEPTH; i++) push(32'(i), 0);
    chk("full_fill", 32'(fill_count), 8);
    chk("full_tready", 32'(s_tready), 0);
    wb_xfer(0, STAT, 0, r);
    chk("full_stat", r, 32'h802);
    @(negedge wb_clk_i);
    if (wbs_ack_o) @(negedge wb_clk_i);
    s_tvalid = 1; s_tdata = 32'd9; s_tlast = 0;
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 0; wbs_adr_i = DATA;
    @(posedge wb_clk_i); #1;
    e = sb.pop_front();
    chk("full_pop_ack", 32'(wbs_ack_o), 1);
    chk("full_pop_dat", wbs_dat_o, e[31:0]);
    chk("full_pop_fill", 32'(fill_count), 7);
    chk("full_pop_tready", 32'(s_tready), 1);
    wbs_stb_i = 0; wbs_cyc_i = 0;
    @(posedge wb_clk_i); #1;
    s_tvalid = 0;
    sb.push_back({1'b0, 32'd9});
    chk("ninth_fill", 32'(fill_count), 8);
    for (int i = 0; i < DEPTH; i++) begin
      e = sb.pop_front();
      wb_xfer(0, DATA, 0, r);
      chk($sformatf("drain%0d", i), r, e[31:0]);
    end
    chk("drain_fill", 32'(fill_count), 0);
    // Held strobe: one ack every two cycles, data zero whenever ack is low.
    @(negedge wb_clk_i);
    if (wbs_ack_o) @(negedge wb_clk_i);
    acks = 0; bad = 0;
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_adr_i = STAT;
    repeat (4) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) acks++;
      else if (wbs_dat_o != 0) bad++;
    end
    chk("held_acks", 32'(acks), 2);
    chk("held_dat_idle", 32'(bad), 0);
    wbs_adr_i = 32'h3000_0098; acks = 0; bad = 0;
    @(posedge wb_clk_i);
    repeat (3) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) acks++;
      if (wbs_dat_o != 0) bad++;
    end
    chk("miss_acks", 32'(acks), 0);
    chk("miss_dat", 32'(bad), 0);
    wbs_stb_i = 0; wbs_cyc_i = 0;
    wb_xfer(1, STAT, 32'hC, r);
    // Streaming: producer at full rate, consumer reading DATA back-to-back.
    maxc = 0; got = 0;
    fork
      for (int i = 0; i < 20; i++) push(32'(100 + i), i == 19);
      for (int k = 0; k < 200 && got < 20; k++) begin
        wb_xfer(0, DATA, 0, r);
        if (r != 0) begin
          e = (sb.size() > 0) ? sb.pop_front() : '0;
          chk($sformatf("stream%0d", got), r, e[31:0]);
          got++;
        end
      end
    join
    chk("stream_count", 32'(got), 20);
    chk("stream_left", 32'(sb.size()), 0);
    chk("stream_max", 32'(maxc <= DEPTH), 1);
    // Reset during a pending read discards everything.
    push(32'd55, 0);
    push(32'd66, 0);
    @(negedge wb_clk_i);
    if (wbs_ack_o) @(negedge wb_clk_i);
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_adr_i = DATA; wb_rst_i = 1;
    @(posedge wb_clk_i); #1;
    chk("mid_rst_ack", 32'(wbs_ack_o), 0);
    chk("mid_rst_dat", wbs_dat_o, 0);
    chk("mid_rst_fill", 32'(fill_count), 0);
    wb_rst_i = 0; wbs_stb_i = 0; wbs_cyc_i = 0;
    sb.delete();
    wb_xfer(0, STAT, 0, r);
    chk("mid_rst_stat", r, 32'h1);
`ifdef RX_FIFO_IRQ_EN
    for (int i = 0; i < 3; i++) push(32'(200 + i), 0);
    chk("irq_at3", 32'(irq), 0);
    push(32'd203, 0);
    chk("irq_at4", 32'(irq), 1);
    wb_xfer(0, DATA, 0, r);
    chk("irq_drop3", 32'(irq), 0);
    wb_xfer(0, DATA, 0, r);
    push(32'd204, 1);
    chk("irq_last", 32'(irq), 1);
    wb_xfer(1, STAT, 32'h4, r);
    chk("irq_w1c", 32'(irq), 0);
`else
    for (int i = 0; i < 5; i++) push(32'(200 + i), i == 4);
    chk("irq_off", 32'(irq), 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_axis_rx_fifo.md
Name: wb_axis_rx_fifo

Overview:
- Downstream of the FIR engine's sm AXI-Stream output.
- Buffers output samples Y[n] in a small FIFO so firmware can drain them over Wishbone at its own pace, without holding the stream handshake open.
- Exposes a pop-on-read data register and a status register in the user-project Wishbone space.
- Acks only its own addresses; its ack/data are OR-muxed with the other user slaves.

Parameters:
- DATA_W, 32, stream sample width and Wishbone data width.
- DEPTH, 8, FIFO entries; power of two, 2..64.
- DATA_ADDR, 32'h3000_0090, word address of the pop-on-read data register.
- STAT_ADDR, 32'h3000_0094, word address of the status register.
- IRQ_THRESH, 4, fill level that raises the interrupt (optional feature only).

Ports:
- wb_clk_i  in  1  sole clock, shared by Wishbone and stream.
- wb_rst_i  in  1  synchronous reset, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  byte selects; ignored, full-word access only.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- s_tvalid  in  1  sample valid from FIR sm port.
- s_tdata  in  DATA_W  sample.
- s_tlast  in  1  last sample of frame.
- s_tready  out  1  FIFO can accept.
- fill_count  out  $clog2(DEPTH)+1  current occupancy.
- irq  out  1  level interrupt.

Behaviour:
- Reset (wb_rst_i high at a clock edge):
  - Read/write pointers and count go to 0.
  - wbs_ack_o=0, wbs_dat_o=0, irq=0.
  - Sticky bits cleared; FIFO contents don't care.
  - Reset mid-transfer discards all buffered samples and any pending ack.
- Storage: each entry holds {tlast, tdata}. Pointers wrap modulo DEPTH. Full when count==DEPTH; empty when count==0.
- Stream side:
  - s_tready = ~full, combinational from the count register.
  - Push on s_tvalid & s_tready at the clock edge.
- Wishbone decode: hit = stb & cyc & (adr==DATA_ADDR | adr==STAT_ADDR). Other addresses are ignored: no ack, and wbs_dat_o is held at 0.
- Ack timing:
  - Ack is registered, asserted exactly one cycle after a hit is sampled with ack low.
  - Ack is high for one cycle, then low for at least one cycle.
  - A held strobe therefore yields one ack per two cycles.
  - wbs_dat_o is valid while ack is high and is 0 otherwise.
- Read DATA_ADDR:
  - Non-empty: return head tdata and pop at the edge where ack is raised.
  - Empty: return 0, set underflow sticky, no pop.
  - Read of empty is never bypassed from a same-cycle push.
- Write DATA_ADDR: acked, no effect.
- Read STAT_ADDR:
  - [0] empty
  - [1] full
  - [2] last_seen sticky: set by pushing an entry with tlast=1
  - [3] underflow sticky
  - [4] head entry tlast bit (0 if empty)
  - [15:8] fill_count (zero-extended)
  - others 0
- Write STAT_ADDR:
  - W1C on bits [3:2].
  - Other bits ignored.
  - If a set event and a clear happen in the same cycle, set wins.
- Simultaneous push and pop: both happen; count is unchanged; pointers both advance. If full, no push that cycle (s_tready=0), even if a pop occurs; s_tready rises the following cycle.
- fill_count is the registered count after the edge.

Optional Feature:
- Macro RX_FIFO_IRQ_EN.
- Defined: irq is registered, high when fill_count >= IRQ_THRESH or last_seen=1. It clears once both conditions are false (drain below threshold and W1C last_seen).
- Undefined: irq is tied 0 and IRQ_THRESH is unused.

Test Plan:
- Reset: hold wb_rst_i 2 cycles -> ack=0, dat_o=0, s_tready=1, fill_count=0, status read = 0x0000_0001.
- Push 3 samples (10, -20, 30, last on 30) with no reads, then read DATA 3 times -> data 10, 0xFFFF_FFEC, 30. Before the third read, status bit4=1; afterwards status = 0x0000_0005 (empty + last_seen).
- Push 8 samples without reading -> fill_count=8, s_tready=0, status[1]=1. One DATA read -> s_tready=1 next cycle; a 9th sample is accepted; fill_count=8.
- Read DATA while empty -> ack after 1 cycle, data 0, status bit3=1. Write STAT 0x8 -> bit3=0.
- Continuous s_tvalid with a DATA read every 2 cycles -> no loss, output order matches input for 20 samples, count never exceeds DEPTH.
- RX_FIFO_IRQ_EN defined, IRQ_THRESH=4 -> irq rises the cycle after the 4th push and falls after the read that leaves count at 3. A tlast push re-raises irq until W1C of bit2.
